// File: rtl/dmem_arbiter_pkg.sv
// Shared types and the arbitration decision for the data-memory arbiter.
// Used by dmem_arbiter (optional perf counters via DMEM_ARB_PERF_EN) and arb_wait_counter.
package dmem_arb_pkg;

    localparam int WAIT_W = 4;

    typedef enum logic [1:0] {
        RESP_NONE,
        RESP_CPU,
        RESP_VGA
    } resp_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_CPU,
        GNT_VGA
    } grant_t;

    // VGA is real time and normally wins; a saturated starvation count hands the conflict to the CPU.
    function automatic grant_t arbitrate(input logic cpu_req, input logic vga_req, input logic sat);
        grant_t g;
        g = GNT_NONE;
        if (cpu_req && vga_req) begin
            g = sat ? GNT_CPU : GNT_VGA;
        end else if (cpu_req) begin
            g = GNT_CPU;
        end else if (vga_req) begin
            g = GNT_VGA;
        end
        return g;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the CPU load/store path, the VGA fetch engine and the data RAM.
// The arbiter sits on the slave modport; the environment drives the master side.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic [DATA_W-1:0] vga_rdata;
    logic              vga_rvalid;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, mem_rdata,
        output cpu_stall, cpu_rdata, cpu_rvalid, vga_rdata, vga_rvalid,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, mem_rdata,
        input  cpu_stall, cpu_rdata, cpu_rvalid, vga_rdata, vga_rvalid,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter_wait_counter.sv
// Saturating count of consecutive denied CPU cycles; sat tells the arbiter the CPU is owed a grant.
module arb_wait_counter
    import dmem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic srst,
    input  logic inc,
    input  logic clr,
    output logic sat
);
    logic [WAIT_W-1:0] cnt_reg;

    assign sat = (cnt_reg == WAIT_W'(MAX_WAIT));

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (inc && !sat) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data RAM: VGA priority with CPU starvation guard.
// Define DMEM_ARB_PERF_EN to add the conflict_cnt / cpu_stall_cnt performance counters.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]    conflict_cnt,
    output logic [31:0]    cpu_stall_cnt
`endif
);
    grant_t            grant;
    logic              sat;
    logic              cpu_grant;
    logic              vga_grant;
    logic              cpu_denied;
    resp_t             resp_reg;
    resp_t             resp_next;
    logic [1:0]        rvalid;
    logic [DATA_W-1:0] rdata [2];

    assign grant      = arbitrate(bus.cpu_req, bus.vga_req, sat);
    assign cpu_grant  = (grant == GNT_CPU);
    assign vga_grant  = (grant == GNT_VGA);
    assign cpu_denied = bus.cpu_req & ~cpu_grant;

    arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait (
        .clk  (clk),
        .srst (rst),
        .inc  (cpu_denied),
        .clr  (cpu_grant | ~bus.cpu_req),
        .sat  (sat)
    );

    // Only the CPU ever writes, so wdata needs no mux.
    assign bus.mem_en    = (cpu_grant | vga_grant) & ~rst;
    assign bus.mem_we    = cpu_grant & bus.cpu_we & ~rst;
    assign bus.mem_addr  = cpu_grant ? bus.cpu_addr : bus.vga_addr;
    assign bus.mem_wdata = bus.cpu_wdata;
    assign bus.cpu_stall = cpu_denied & ~rst;

    always_comb begin
        resp_next = RESP_NONE;
        if (cpu_grant && !bus.cpu_we) begin
            resp_next = RESP_CPU;
        end else if (vga_grant) begin
            resp_next = RESP_VGA;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_reg <= RESP_NONE;
        end else begin
            resp_reg <= resp_next;
        end
    end

    // Lane 0 returns to the CPU, lane 1 to VGA; data is zeroed outside its valid cycle.
    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_lane
        assign rvalid[gi] = ~rst & (resp_reg == ((gi == 0) ? RESP_CPU : RESP_VGA));
        assign rdata[gi]  = rvalid[gi] ? bus.mem_rdata : '0;
    end

    assign bus.cpu_rvalid = rvalid[0];
    assign bus.cpu_rdata  = rdata[0];
    assign bus.vga_rvalid = rvalid[1];
    assign bus.vga_rdata  = rdata[1];

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] conflict_reg;
    logic [31:0] stall_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_reg <= '0;
            stall_reg    <= '0;
        end else begin
            if (bus.cpu_req && bus.vga_req) conflict_reg <= conflict_reg + 32'd1;
            if (cpu_denied)                 stall_reg    <= stall_reg + 32'd1;
        end
    end

    assign conflict_cnt  = conflict_reg;
    assign cpu_stall_cnt = stall_reg;
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: cycle table plus hand sequences for starvation clearing.
module tb_dmem_arbiter;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    dmem_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus ();

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] conflict_cnt;
    logic [31:0] cpu_stall_cnt;
`endif

    dmem_arbiter #(
        .ADDR_W   (16),
        .DATA_W   (32),
        .MAX_WAIT (4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus)
`ifdef DMEM_ARB_PERF_EN
        ,
        .conflict_cnt  (conflict_cnt),
        .cpu_stall_cnt (cpu_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM model with a preload port used only during reset.
    logic [31:0] ram [256];
    logic        load_en;
    logic [7:0]  load_addr;
    logic [31:0] load_data;

    always @(posedge clk) begin
        if (load_en) begin
            ram[load_addr] <= load_data;
        end else if (bus.mem_en) begin
            if (bus.mem_we) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
            else            bus.mem_rdata <= ram[bus.mem_addr[7:0]];
        end
    end

    typedef struct {
        logic        rst;
        logic        creq;
        logic        cwe;
        logic [15:0] caddr;
        logic [31:0] cwd;
        logic        vreq;
        logic [15:0] vaddr;
        logic        en;
        logic        we;
        logic [15:0] maddr;
        logic        stall;
        logic        crv;
        logic [31:0] crd;
        logic        vrv;
        logic [31:0] vrd;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];

    function automatic vec_t mk(logic r, logic cq, logic cw, logic [15:0] ca, logic [31:0] cd,
                                logic vq, logic [15:0] va, logic e, logic w, logic [15:0] ma,
                                logic st, logic crv, logic [31:0] crd, logic vrv, logic [31:0] vrd);
        vec_t v;
        v.rst = r;   v.creq = cq; v.cwe = cw; v.caddr = ca; v.cwd = cd;
        v.vreq = vq; v.vaddr = va; v.en = e; v.we = w; v.maddr = ma;
        v.stall = st; v.crv = crv; v.crd = crd; v.vrv = vrv; v.vrd = vrd;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic cq, input logic cw, input logic [15:0] ca,
                         input logic [31:0] cd, input logic vq, input logic [15:0] va);
        rst = r;
        bus.cpu_req = cq; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
        bus.vga_req = vq; bus.vga_addr = va;
    endtask

    // Holds both read requests for five cycles: four VGA grants with CPU stalled, then the CPU.
    task automatic both_run(input string name);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 1'b0, 16'h0010, 32'h0, 1'b1, 16'h0050);
            #1;
            chk({name, "_stall"}, k, {31'b0, bus.cpu_stall}, (k < 4) ? 32'd1 : 32'd0);
            chk({name, "_addr"}, k, {16'b0, bus.mem_addr}, (k < 4) ? 32'h0050 : 32'h0010);
        end
        $display("[TB] sequence %s done", name);
    endtask

    task automatic hold_both(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 1'b0, 16'h0010, 32'h0, 1'b1, 16'h0050);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        bus.mem_rdata = '0;
        drive(1'b1, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 16'h0);

        vecs[0]  = mk(1,0,0,16'h0000,32'h0,       0,16'h0000, 0,0,16'h0000,0, 0,32'h0,        0,32'h0);
        vecs[1]  = mk(0,1,0,16'h0010,32'h0,       0,16'h0000, 1,0,16'h0010,0, 0,32'h0,        0,32'h0);
        vecs[2]  = mk(0,0,0,16'h0000,32'h0,       0,16'h0000, 0,0,16'h0000,0, 1,32'hDEADBEEF, 0,32'h0);
        vecs[3]  = mk(0,1,0,16'h0040,32'h0,       1,16'h0050, 1,0,16'h0050,1, 0,32'h0,        0,32'h0);
        vecs[4]  = mk(0,1,0,16'h0040,32'h0,       1,16'h0050, 1,0,16'h0050,1, 0,32'h0,        1,32'h0BAD0050);
        vecs[5]  = vecs[4];
        vecs[6]  = vecs[4];
        vecs[7]  = mk(0,1,0,16'h0040,32'h0,       1,16'h0050, 1,0,16'h0040,0, 0,32'h0,        1,32'h0BAD0050);
        vecs[8]  = mk(0,1,0,16'h0040,32'h0,       1,16'h0050, 1,0,16'h0050,1, 1,32'hC0DE0040, 0,32'h0);
        vecs[9]  = mk(0,0,0,16'h0000,32'h0,       0,16'h0000, 0,0,16'h0000,0, 0,32'h0,        1,32'h0BAD0050);
        vecs[10] = mk(0,1,1,16'h0020,32'h12345678,0,16'h0000, 1,1,16'h0020,0, 0,32'h0,        0,32'h0);
        vecs[11] = mk(0,0,0,16'h0000,32'h0,       1,16'h0020, 1,0,16'h0020,0, 0,32'h0,        0,32'h0);
        vecs[12] = mk(0,0,0,16'h0000,32'h0,       0,16'h0000, 0,0,16'h0000,0, 0,32'h0,        1,32'h12345678);
        vecs[13] = mk(0,1,1,16'h0030,32'h55555555,1,16'h0030, 1,0,16'h0030,1, 0,32'h0,        0,32'h0);
        vecs[14] = mk(0,1,1,16'h0030,32'h55555555,0,16'h0000, 1,1,16'h0030,0, 0,32'h0,        1,32'hAAAA0000);
        vecs[15] = mk(0,0,0,16'h0000,32'h0,       0,16'h0000, 0,0,16'h0000,0, 0,32'h0,        0,32'h0);
        vecs[16] = mk(0,0,0,16'h0000,32'h0,       1,16'h0030, 1,0,16'h0030,0, 0,32'h0,        0,32'h0);
        vecs[17] = mk(1,0,0,16'h0000,32'h0,       0,16'h0000, 0,0,16'h0000,0, 0,32'h0,        0,32'h0);
        vecs[18] = mk(0,1,0,16'h0010,32'h0,       1,16'h0050, 1,0,16'h0050,1, 0,32'h0,        0,32'h0);
        vecs[19] = mk(0,1,0,16'h0010,32'h0,       1,16'h0050, 1,0,16'h0050,1, 0,32'h0,        1,32'h0BAD0050);
        vecs[20] = vecs[19];
        vecs[21] = vecs[19];
        vecs[22] = mk(0,1,0,16'h0010,32'h0,       1,16'h0050, 1,0,16'h0010,0, 0,32'h0,        1,32'h0BAD0050);
        vecs[23] = mk(0,0,0,16'h0000,32'h0,       0,16'h0000, 0,0,16'h0000,0, 1,32'hDEADBEEF, 0,32'h0);
        vecs[24] = mk(0,0,0,16'h0000,32'h0,       1,16'h0030, 1,0,16'h0030,0, 0,32'h0,        0,32'h0);
        vecs[25] = mk(0,0,0,16'h0000,32'h0,       0,16'h0000, 0,0,16'h0000,0, 0,32'h0,        1,32'h55555555);

        // Preload RAM while the DUT is held in reset.
        for (int p = 0; p < 4; p++) begin
            @(negedge clk);
            load_en   = 1'b1;
            load_addr = (p == 0) ? 8'h10 : (p == 1) ? 8'h30 : (p == 2) ? 8'h40 : 8'h50;
            load_data = (p == 0) ? 32'hDEADBEEF : (p == 1) ? 32'hAAAA0000 :
                        (p == 2) ? 32'hC0DE0040 : 32'h0BAD0050;
        end
        @(negedge clk);
        load_en = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].creq, vecs[i].cwe, vecs[i].caddr, vecs[i].cwd,
                  vecs[i].vreq, vecs[i].vaddr);
            #1;
            chk("mem_en",     i, {31'b0, bus.mem_en},     {31'b0, vecs[i].en});
            chk("mem_we",     i, {31'b0, bus.mem_we},     {31'b0, vecs[i].we});
            if (vecs[i].en) chk("mem_addr", i, {16'b0, bus.mem_addr}, {16'b0, vecs[i].maddr});
            if (vecs[i].we) chk("mem_wdata", i, bus.mem_wdata, vecs[i].cwd);
            chk("cpu_stall",  i, {31'b0, bus.cpu_stall},  {31'b0, vecs[i].stall});
            chk("cpu_rvalid", i, {31'b0, bus.cpu_rvalid}, {31'b0, vecs[i].crv});
            chk("cpu_rdata",  i, bus.cpu_rdata,           vecs[i].crd);
            chk("vga_rvalid", i, {31'b0, bus.vga_rvalid}, {31'b0, vecs[i].vrv});
            chk("vga_rdata",  i, bus.vga_rdata,           vecs[i].vrd);
            $display("[TB] vector %0d applied", i);
        end

        // Reset in the middle of a starvation run must restart the count from zero.
        hold_both(3);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 16'h0010, 32'h0, 1'b1, 16'h0050);
        #1;
        chk("rst_stall", 0, {31'b0, bus.cpu_stall}, 32'd0);
        chk("rst_en",    0, {31'b0, bus.mem_en},    32'd0);
        both_run("after_rst");

        // Dropping cpu_req for a cycle also clears the count.
        hold_both(3);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 16'h0010, 32'h0, 1'b1, 16'h0050);
        #1;
        chk("drop_stall", 0, {31'b0, bus.cpu_stall}, 32'd0);
        both_run("after_drop");

`ifdef DMEM_ARB_PERF_EN
        @(negedge clk);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 16'h0);
        hold_both(10);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 16'h0);
        #1;
        chk("conflict_cnt",  0, conflict_cnt,  32'd10);
        chk("cpu_stall_cnt", 0, cpu_stall_cnt, 32'd8);
        $display("[TB] sequence perf done");
`endif

        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 16'h0, 32'h0, 1'b0, 16'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
